// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TX/RX FIFOs, sticky error flags, programmable
// baud divisor and a level interrupt, on a 4-word register window.
module uart_mmio #(
  parameter int CLKDIV  = 434,
  parameter int TXDEPTH = 16,
  parameter int RXDEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);
  localparam int TXAW = $clog2(TXDEPTH);
  localparam int RXAW = $clog2(RXDEPTH);
  localparam logic [TXAW:0] TX_INC  = {{TXAW{1'b0}}, 1'b1};
  localparam logic [RXAW:0] RX_INC  = {{RXAW{1'b0}}, 1'b1};
  localparam logic [15:0]   DIV_RST = 16'(CLKDIV);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_st_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_st_t;

  logic wr_data, wr_stat, wr_ctrl, wr_div, rd_data;
  assign wr_data = sel & we & (addr == 2'd0);
  assign wr_stat = sel & we & (addr == 2'd1);
  assign wr_ctrl = sel & we & (addr == 2'd2);
  assign wr_div  = sel & we & (addr == 2'd3);
  assign rd_data = sel & re & (addr == 2'd0);

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:16];

  logic [7:0]    tx_mem [TXDEPTH];
  logic [7:0]    rx_mem [RXDEPTH];
  logic [TXAW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [RXAW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [15:0]   div_q, div_d;
  logic          tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d, ferr_q, ferr_d;
  tx_st_t        tx_st_q, tx_st_d;
  logic [15:0]   tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_q, tx_d;
  rx_st_t        rx_st_q, rx_st_d;
  logic [15:0]   rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_s1_q, rx_s2_q, rx_s3_q;

  logic tx_empty, tx_full, tx_push, tx_pop, tx_busy, tx_bit_end;
  logic rx_valid, rx_full, rx_push, rx_pop, rx_push_req, rx_ferr, rx_hit;
  logic [15:0] rx_tgt;

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[TXAW] != tx_rp_q[TXAW]) &&
                    (tx_wp_q[TXAW-1:0] == tx_rp_q[TXAW-1:0]);
  assign rx_valid = (rx_wp_q != rx_rp_q);
  assign rx_full  = (rx_wp_q[RXAW] != rx_rp_q[RXAW]) &&
                    (rx_wp_q[RXAW-1:0] == rx_rp_q[RXAW-1:0]);
  assign tx_push  = wr_data & (~tx_full | tx_pop);
  assign rx_pop   = rd_data & rx_valid;
  assign rx_push  = rx_push_req & (~rx_full | rx_pop);

  assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);
  assign rx_tgt     = (rx_st_q == RX_START) ? {1'b0, rx_div_q[15:1]} : rx_div_q;
  assign rx_hit     = (rx_cnt_q == rx_tgt - 16'd1);

  // State register: control state resets, FIFO storage and shifters do not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp_q <= '0; tx_rp_q <= '0; rx_wp_q <= '0; rx_rp_q <= '0;
      ctrl_q <= '0; div_q <= DIV_RST;
      tx_ovf_q <= 1'b0; rx_ovr_q <= 1'b0; ferr_q <= 1'b0;
      tx_st_q <= TX_IDLE; tx_cnt_q <= '0; tx_div_q <= DIV_RST; tx_bit_q <= '0;
      tx_q <= 1'b1;
      rx_st_q <= RX_IDLE; rx_cnt_q <= '0; rx_div_q <= DIV_RST; rx_bit_q <= '0;
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_s3_q <= 1'b1;
    end else begin
      tx_wp_q <= tx_wp_d; tx_rp_q <= tx_rp_d; rx_wp_q <= rx_wp_d; rx_rp_q <= rx_rp_d;
      ctrl_q <= ctrl_d; div_q <= div_d;
      tx_ovf_q <= tx_ovf_d; rx_ovr_q <= rx_ovr_d; ferr_q <= ferr_d;
      tx_st_q <= tx_st_d; tx_cnt_q <= tx_cnt_d; tx_div_q <= tx_div_d; tx_bit_q <= tx_bit_d;
      tx_q <= tx_d;
      rx_st_q <= rx_st_d; rx_cnt_q <= rx_cnt_d; rx_div_q <= rx_div_d; rx_bit_q <= rx_bit_d;
      rx_s1_q <= rx; rx_s2_q <= rx_s1_q; rx_s3_q <= rx_s2_q;
    end
  end

  always_ff @(posedge clk) begin
    tx_sh_q <= tx_sh_d;
    rx_sh_q <= rx_sh_d;
    if (tx_push) tx_mem[tx_wp_q[TXAW-1:0]] <= wdata[7:0];
    if (rx_push) rx_mem[rx_wp_q[RXAW-1:0]] <= rx_sh_q;
  end

  // Next state: registers, FIFO pointers, sticky flags (a set wins over a clear).
  always_comb begin
    ctrl_d   = wr_ctrl ? wdata[1:0] : ctrl_q;
    div_d    = div_q;
    if (wr_div) div_d = (wdata[15:0] < 16'd4) ? 16'd4 : wdata[15:0];
    tx_wp_d  = tx_push ? tx_wp_q + TX_INC : tx_wp_q;
    tx_rp_d  = tx_pop  ? tx_rp_q + TX_INC : tx_rp_q;
    rx_wp_d  = rx_push ? rx_wp_q + RX_INC : rx_wp_q;
    rx_rp_d  = rx_pop  ? rx_rp_q + RX_INC : rx_rp_q;
    tx_ovf_d = (tx_ovf_q & ~(wr_stat & wdata[4])) | (wr_data & ~tx_push);
    rx_ovr_d = (rx_ovr_q & ~(wr_stat & wdata[5])) | (rx_push_req & ~rx_push);
    ferr_d   = (ferr_q   & ~(wr_stat & wdata[6])) | rx_ferr;
  end

  // TX next state; a pop always (re)starts a frame with the current divisor.
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q + 16'd1;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_div_d = tx_div_q;
    if (tx_pop) begin
      tx_st_d  = TX_START;
      tx_cnt_d = '0;
      tx_sh_d  = tx_mem[tx_rp_q[TXAW-1:0]];
      tx_div_d = div_q;
    end else begin
      case (tx_st_q)
        TX_IDLE:  tx_cnt_d = '0;
        TX_START: if (tx_bit_end) begin
                    tx_st_d = TX_DATA; tx_cnt_d = '0; tx_bit_d = '0;
                  end
        TX_DATA:  if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    if (tx_bit_q == 3'd7) tx_st_d = TX_STOP;
                    else                  tx_bit_d = tx_bit_q + 3'd1;
                  end
        TX_STOP:  if (tx_bit_end) begin
                    tx_st_d = TX_IDLE; tx_cnt_d = '0;
                  end
        default:  tx_st_d = TX_IDLE;
      endcase
    end
  end

  // TX outputs; tx is registered so the line lags the state by one cycle.
  always_comb begin
    tx_pop  = ~tx_empty & ((tx_st_q == TX_IDLE) | ((tx_st_q == TX_STOP) & tx_bit_end));
    tx_busy = (tx_st_q != TX_IDLE);
    case (tx_st_q)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_sh_q[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // RX next state
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q + 16'd1;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_div_d = rx_div_q;
    case (rx_st_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_s3_q & ~rx_s2_q) begin
          rx_st_d = RX_START; rx_div_d = div_q;
        end
      end
      RX_START: if (rx_hit) begin
                  rx_cnt_d = '0; rx_bit_d = '0;
                  rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
                end
      RX_DATA:  if (rx_hit) begin
                  rx_cnt_d = '0;
                  rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                  if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
                  else                  rx_bit_d = rx_bit_q + 3'd1;
                end
      RX_STOP:  if (rx_hit) begin
                  rx_cnt_d = '0;
                  rx_st_d  = rx_s2_q ? RX_IDLE : RX_WAIT;
                end
      RX_WAIT: begin
        rx_cnt_d = '0;
        if (rx_s2_q) rx_st_d = RX_IDLE;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // RX outputs
  always_comb begin
    rx_push_req = (rx_st_q == RX_STOP) & rx_hit &  rx_s2_q;
    rx_ferr     = (rx_st_q == RX_STOP) & rx_hit & ~rx_s2_q;
  end

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0: if (rx_valid) rdata = {23'b0, 1'b1, rx_mem[rx_rp_q[RXAW-1:0]]};
      2'd1: rdata = {24'b0, tx_busy, ferr_q, rx_ovr_q, tx_ovf_q,
                     rx_full, rx_valid, tx_empty, tx_full};
      2'd2: rdata = {30'b0, ctrl_q};
      default: rdata = {16'b0, div_q};
    endcase
  end

  assign tx  = tx_q;
  assign irq = (ctrl_q[0] & rx_valid) | (ctrl_q[1] & tx_empty & ~tx_busy);
endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio: register table, hand-timed corner sequences and
// randomized loopback traffic checked against a serial-line/queue model.
module tb_uart_mmio;
  localparam int CLKDIV = 24;

  logic        clk = 1'b0, reset, sel, we, re;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata;
  logic        tx, rx_in, irq, rx_drv, loop_en;

  assign rx_in = loop_en ? tx : rx_drv;

  uart_mmio #(.CLKDIV(CLKDIV), .TXDEPTH(4), .RXDEPTH(2)) dut (
    .clk(clk), .reset(reset), .sel(sel), .addr(addr), .we(we), .re(re),
    .wdata(wdata), .rdata(rdata), .tx(tx), .rx(rx_in), .irq(irq));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int tb_div;
  logic [7:0] mon_q[$];
  logic       mon_prev = 1'b1;
  logic [7:0] mon_b;
  int         mon_d;

  // Line monitor: decodes 8N1 frames on tx at bit centres using tb_div.
  always begin
    @(negedge clk);
    if (!reset && mon_prev && !tx) begin
      mon_d = tb_div;
      repeat (mon_d / 2) @(negedge clk);
      if (!tx) begin
        for (int i = 0; i < 8; i++) begin
          repeat (mon_d) @(negedge clk);
          mon_b[i] = tx;
        end
        repeat (mon_d) @(negedge clk);
        if (tx) mon_q.push_back(mon_b);
      end
    end
    mon_prev = tx;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1 sel = 1'b0; we = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1 d = rdata;
  endtask

  task automatic rd_pop(output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; re = 1'b1; addr = 2'd0;
    #1 d = rdata;
    @(posedge clk);
    #1 sel = 1'b0; re = 1'b0;
  endtask

  task automatic wait_rx(input string name, input int budget);
    logic [31:0] s;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      peek(2'd1, s);
      if (s[2]) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_tx_idle(input string name, input int budget);
    logic [31:0] s;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      peek(2'd1, s);
      if (s[1] && !s[7]) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb, input int d);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (d) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (d) @(negedge clk);
    end
    rx_drv = stopb;
    repeat (d) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        exp_irq;
  } vec_t;

  vec_t vt[10];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] s, d;
    logic [9:0]  fr;
    logic [7:0]  b;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_mon[$];
    int          k, j, n, dv, budget;

    vt[0] = '{2'd1, 1'b0, 32'h0,          32'h2,      1'b0};
    vt[1] = '{2'd2, 1'b0, 32'h0,          32'h0,      1'b0};
    vt[2] = '{2'd3, 1'b0, 32'h0,          CLKDIV,     1'b0};
    vt[3] = '{2'd0, 1'b0, 32'h0,          32'h0,      1'b0};
    vt[4] = '{2'd3, 1'b1, 32'h2,          32'h4,      1'b0};
    vt[5] = '{2'd3, 1'b1, 32'h0001_1234,  32'h1234,   1'b0};
    vt[6] = '{2'd2, 1'b1, 32'hFFFF_FFFF,  32'h3,      1'b1};
    vt[7] = '{2'd2, 1'b1, 32'h1,          32'h1,      1'b0};
    vt[8] = '{2'd1, 1'b1, 32'h70,         32'h2,      1'b0};
    vt[9] = '{2'd3, 1'b1, 32'h8,          32'h8,      1'b0};

    reset = 1'b1; sel = 1'b0; we = 1'b0; re = 1'b0; addr = 2'd0; wdata = '0;
    rx_drv = 1'b1; loop_en = 1'b0; tb_div = CLKDIV;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_irq", 32'(irq), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (vt[i].wr) wr(vt[i].addr, vt[i].wdata);
      @(negedge clk);
      peek(vt[i].addr, s);
      check($sformatf("reg_vec%0d", i), s, vt[i].exp);
      check($sformatf("reg_vec%0d_irq", i), 32'(irq), 32'(vt[i].exp_irq));
    end
    tb_div = 8;

    // 0x55 at DIV=8: exact bit timing, busy and irq.
    wr(2'd2, 32'h2);
    @(negedge clk);
    check("txe_irq_idle", 32'(irq), 32'd1);
    fr = {1'b1, 8'h55, 1'b0};
    wr(2'd0, 32'h55);
    @(negedge clk);
    check("txe_irq_pending", 32'(irq), 32'd0);
    for (int c = 1; c <= 84; c++) begin
      @(negedge clk);
      if (c == 1) check("tx55_pre", 32'(tx), 32'd1);
      if (c >= 2 && c <= 81) begin
        k = (c - 2) / 8;
        j = (c - 2) % 8;
        if (j == 0 || j == 7)
          check($sformatf("tx55_bit%0d_c%0d", k, c), 32'(tx), 32'(fr[k]));
      end
      if (c == 40) check("tx55_irq_mid", 32'(irq), 32'd0);
      if (c == 80) begin
        peek(2'd1, s);
        check("tx55_busy_c80", 32'(s[7]), 32'd1);
      end
      if (c == 81) begin
        peek(2'd1, s);
        check("tx55_busy_c81", 32'(s[7]), 32'd0);
        check("tx55_irq_end", 32'(irq), 32'd1);
      end
    end
    check("tx55_mon_cnt", 32'(mon_q.size()), 32'd1);
    if (mon_q.size() > 0) check("tx55_mon_byte", 32'(mon_q[0]), 32'h55);
    mon_q.delete();

    // Six back-to-back writes into a 4-deep FIFO: five fit, one dropped.
    for (int i = 0; i < 6; i++) wr(2'd0, 32'h10 + 32'(i));
    peek(2'd1, s);
    check("ovf_set", 32'(s[4]), 32'd1);
    wr(2'd1, 32'h10);
    peek(2'd1, s);
    check("ovf_clr", 32'(s[4]), 32'd0);
    wait_tx_idle("ovf_drain", 700);
    repeat (4) @(negedge clk);
    check("ovf_mon_cnt", 32'(mon_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("ovf_byte%0d", i),
            (i < mon_q.size()) ? 32'(mon_q[i]) : 32'hFFFF_FFFF, 32'h10 + 32'(i));
    mon_q.delete();

    // Loopback 0xA3.
    loop_en = 1'b1;
    wr(2'd0, 32'hA3);
    wait_rx("lb_wait", 200);
    peek(2'd0, s);
    check("lb_peek", s, 32'h1A3);
    rd_pop(d);
    check("lb_pop", d, 32'h1A3);
    peek(2'd0, s);
    check("lb_after", s, 32'h0);
    peek(2'd1, s);
    check("lb_valid_after", 32'(s[2]), 32'd0);
    wait_tx_idle("lb_drain", 100);
    repeat (4) @(negedge clk);
    mon_q.delete();
    loop_en = 1'b0;

    // Framing error then a good frame.
    send_rx(8'h3C, 1'b0, 8);
    repeat (20) @(negedge clk);
    peek(2'd1, s);
    check("ferr_status", s, 32'h42);
    send_rx(8'h81, 1'b1, 8);
    repeat (20) @(negedge clk);
    peek(2'd0, s);
    check("ferr_next_byte", s, 32'h181);
    rd_pop(d);
    wr(2'd1, 32'h40);
    peek(2'd1, s);
    check("ferr_clr", s, 32'h02);

    // Three frames into a 2-deep RX FIFO.
    send_rx(8'h11, 1'b1, 8);
    send_rx(8'h22, 1'b1, 8);
    send_rx(8'h33, 1'b1, 8);
    repeat (20) @(negedge clk);
    peek(2'd1, s);
    check("rxovr_status", s, 32'h2E);
    rd_pop(d);
    check("rxovr_b0", d, 32'h111);
    rd_pop(d);
    check("rxovr_b1", d, 32'h122);
    peek(2'd0, s);
    check("rxovr_empty", s, 32'h0);
    wr(2'd1, 32'h20);
    @(negedge clk);
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (30) @(negedge clk);
    peek(2'd1, s);
    check("glitch_status", s, 32'h02);

    // Reset in the middle of a frame of zeros.
    wr(2'd2, 32'h3);
    for (int i = 0; i < 6; i++) wr(2'd0, 32'h00);
    repeat (30) @(negedge clk);
    check("rst_mid_tx_low", 32'(tx), 32'd0);
    peek(2'd1, s);
    check("rst_mid_ovf", 32'(s[4]), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_tx_async", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    peek(2'd1, s);
    check("rst_status", s, 32'h02);
    peek(2'd3, s);
    check("rst_div", s, CLKDIV);
    peek(2'd2, s);
    check("rst_ctrl", s, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tb_div = CLKDIV;
    repeat (300) @(negedge clk);
    mon_q.delete();
    loop_en = 1'b1;
    wr(2'd0, 32'hFF);
    wait_rx("rst_ff_wait", 600);
    rd_pop(d);
    check("rst_ff_rx", d, 32'h1FF);
    wait_tx_idle("rst_ff_drain", 100);
    repeat (4) @(negedge clk);
    check("rst_ff_mon_cnt", 32'(mon_q.size()), 32'd1);
    if (mon_q.size() > 0) check("rst_ff_mon", 32'(mon_q[0]), 32'hFF);
    mon_q.delete();

    // Randomized loopback bursts against a byte-queue model.
    for (int it = 0; it < 6; it++) begin
      dv = $urandom_range(6, 16);
      wr(2'd3, 32'(dv));
      tb_div = dv;
      n = $urandom_range(1, 4);
      for (int q = 0; q < n; q++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        exp_mon.push_back(b);
        wr(2'd0, {24'b0, b});
      end
      budget = n * 10 * dv + 100;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk);
        peek(2'd1, s);
        if (s[2]) begin
          rd_pop(d);
          check($sformatf("rand%0d_rx", it), d, {23'b0, 1'b1, exp_q.pop_front()});
        end
        budget--;
      end
      if (exp_q.size() > 0) begin
        check($sformatf("rand%0d_timeout", it), 32'(exp_q.size()), 32'd0);
        exp_q.delete();
      end
      wait_tx_idle($sformatf("rand%0d_drain", it), 200);
      repeat (4) @(negedge clk);
      check($sformatf("rand%0d_mon_cnt", it), 32'(mon_q.size()), 32'(exp_mon.size()));
      for (int q = 0; q < exp_mon.size(); q++)
        check($sformatf("rand%0d_mon%0d", it, q),
              (q < mon_q.size()) ? 32'(mon_q[q]) : 32'hFFFF_FFFF, 32'(exp_mon[q]));
      mon_q.delete();
      exp_mon.delete();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
